qam_demap_sequencer: RTL

//  Controller for the 16QAM hard-decision demapper datapath; replaces the empty controller in the top level.

---
 rtl/qam_demap_sequencer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/qam_demap_sequencer.sv
// Sequencer for the 16QAM hard-decision demapper: sclk sync, latch/load/shift bursts, offset calibration, overrun flag.
// Optional macro QAM_SEQ_OVR_CNT_EN adds an 8-bit saturating dropped-symbol counter output ovr_cnt.
module qam_demap_sequencer #(
    parameter int BITS_PER_SYM = 4,
    parameter int CAL_SYMS     = 16,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       dclk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       enable,
    input  logic       calibrate,
    input  logic       ovr_clr,
    output logic       latch_offset,
    output logic       latch_reg,
    output logic       shift,
    output logic       busy,
    output logic       cal_done,
    output logic       overrun,
`ifdef QAM_SEQ_OVR_CNT_EN
    output logic [7:0] ovr_cnt,
`endif
    output logic [2:0] o_dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARM   = 3'd1,
        S_LATCH = 3'd2,
        S_LOAD  = 3'd3,
        S_SHIFT = 3'd4,
        S_CAL   = 3'd5
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_sync_prev;
    logic [3:0]             r_bit_cnt;
    logic [7:0]             r_sym_cnt;
    logic                   r_pending;
    logic                   r_overrun;
    logic                   w_sym_evt;
    logic                   w_last_bit;
    logic                   w_cal_hit;
    logic                   w_in_sym;
    logic                   w_drop;

    assign w_sym_evt  = r_sync[SYNC_STAGES-1] & ~r_sync_prev;
    assign w_last_bit = (r_bit_cnt == 4'(BITS_PER_SYM - 1));
    assign w_cal_hit  = (r_state == S_CAL) && enable && w_sym_evt &&
                        (r_sym_cnt == 8'(CAL_SYMS - 1));
    assign w_in_sym   = (r_state == S_LATCH) || (r_state == S_LOAD) || (r_state == S_SHIFT);
    // A second event while one is already waiting has nowhere to go.
    assign w_drop     = w_sym_evt && r_pending && w_in_sym;

    always_ff @(posedge dclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (enable) w_next = S_ARM;
            S_ARM: begin
                if (!enable)                       w_next = S_IDLE;
                else if (calibrate)                w_next = S_CAL;
                else if (w_sym_evt || r_pending)   w_next = S_LATCH;
            end
            S_LATCH: w_next = S_LOAD;
            S_LOAD:  w_next = S_SHIFT;
            S_SHIFT: begin
                if (w_last_bit) begin
                    if (!enable)                   w_next = S_IDLE;
                    else if (calibrate)            w_next = S_CAL;
                    else if (w_sym_evt || r_pending) w_next = S_LATCH;
                    else                           w_next = S_ARM;
                end
            end
            S_CAL: begin
                if (!enable)                       w_next = S_IDLE;
                else if (w_cal_hit)                w_next = S_ARM;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        latch_reg    = (r_state == S_LATCH);
        shift        = (r_state == S_SHIFT);
        busy         = w_in_sym || (r_state == S_CAL);
        latch_offset = w_cal_hit;
        cal_done     = w_cal_hit;
        overrun      = r_overrun;
        o_dbg_state  = r_state;
    end

    always_ff @(posedge dclk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync      <= '0;
            r_sync_prev <= 1'b0;
            r_bit_cnt   <= '0;
            r_sym_cnt   <= '0;
            r_pending   <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_sync      <= {r_sync[SYNC_STAGES-2:0], sclk};
            r_sync_prev <= r_sync[SYNC_STAGES-1];
            r_bit_cnt   <= (r_state == S_SHIFT) ? r_bit_cnt + 4'd1 : 4'd0;
            if ((r_state == S_CAL) && (w_next == S_CAL)) begin
                if (w_sym_evt) r_sym_cnt <= r_sym_cnt + 8'd1;
            end else begin
                r_sym_cnt <= '0;
            end
            // Entering LATCH consumes the waiting event; entering IDLE/CAL discards it.
            if ((w_next == S_IDLE) || (w_next == S_CAL) || (w_next == S_LATCH)) begin
                r_pending <= 1'b0;
            end else if (w_sym_evt && w_in_sym) begin
                r_pending <= 1'b1;
            end
            if (w_drop)       r_overrun <= 1'b1;
            else if (ovr_clr) r_overrun <= 1'b0;
        end
    end

`ifdef QAM_SEQ_OVR_CNT_EN
    logic [7:0] r_ovr_cnt;
    always_ff @(posedge dclk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovr_cnt <= '0;
        end else if (ovr_clr) begin
            r_ovr_cnt <= w_drop ? 8'd1 : 8'd0;
        end else if (w_drop && (r_ovr_cnt != 8'hFF)) begin
            r_ovr_cnt <= r_ovr_cnt + 8'd1;
        end
    end
    assign ovr_cnt = r_ovr_cnt;
`endif

endmodule
